// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 7-segment scan driver.
//   NUM_DIGITS      : number of multiplexed display positions
//   SEG_*           : active-high 7-bit glyphs {G,F,E,D,C,B,A}
//   AN_OFF/SEG_OFF  : active-low "everything dark" levels
//   frame_t         : one buffered frame of digits plus decimal points
package seg_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // digit[3] is hours-upper, digit[0] is minutes-lower.
    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] digit;
        logic [NUM_DIGITS-1:0]      dp;
    } frame_t;

endpackage

// File: rtl/seg_decode.sv
// BCD digit to active-high segment pattern.
//   value   : 4-bit digit; 10..15 render as a dash
//   dp      : decimal point enable
//   pattern : {DP,G,F,E,D,C,B,A}, active high
module seg_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] pattern
);

    logic [6:0] glyph;

    always_comb begin
        glyph = SEG_DASH;
        case (value)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
        pattern = {dp, glyph};
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver with PWM brightness,
// guard blanking between digits and frame-synchronous double buffering.
//   CLK100MHZ  : system clock
//   RST_N      : asynchronous active-low reset
//   BRIGHT     : PWM duty, used live every cycle
//   LOAD       : strobe capturing HR_U/HR_L/MIN_U/MIN_L/DP_MASK into staging
//   AN         : active-low anode enables, bit i = position i (registered)
//   SEG        : active-low {DP,G,F,E,D,C,B,A} (registered)
//   FRAME_DONE : one-cycle pulse following the frame boundary (registered)
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned FRAME_HZ      = 1000,
    parameter int unsigned GUARD         = 16,
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                CLK100MHZ,
    input  logic                RST_N,
    input  logic [PWM_BITS-1:0] BRIGHT,
    input  logic                LOAD,
    input  logic [3:0]          HR_U,
    input  logic [3:0]          HR_L,
    input  logic [3:0]          MIN_U,
    input  logic [3:0]          MIN_L,
    input  logic [3:0]          DP_MASK,
    output logic [3:0]          AN,
    output logic [7:0]          SEG,
    output logic                FRAME_DONE
);

    localparam int unsigned DWELL = CLK_HZ / (NUM_DIGITS * FRAME_HZ);
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GUARD_END  = CNT_W'(GUARD);

    logic [CNT_W-1:0]    dwell_cnt_q, dwell_cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    frame_t              staging_q, staging_d;
    frame_t              display_q, display_d;
    logic                pending_q, pending_d;
    logic [3:0]          an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_done_q;

    logic       dwell_end;
    logic       boundary;
    logic       blank;
    logic       lit;
    logic [7:0] pattern;

    seg_decode u_decode (
        .value   (display_q.digit[idx_q]),
        .dp      (display_q.dp[idx_q]),
        .pattern (pattern)
    );

    always_comb begin
        dwell_end   = (dwell_cnt_q == DWELL_LAST);
        boundary    = dwell_end && (idx_q == 2'd0);
        dwell_cnt_d = dwell_end ? '0 : dwell_cnt_q + 1'b1;
        // Scan runs 3,2,1,0; the 2-bit wrap takes 0 back to 3.
        idx_d       = dwell_end ? idx_q - 2'd1 : idx_q;
        pwm_cnt_d   = pwm_cnt_q + 1'b1;

        // A LOAD on the boundary commits the old staging and leaves the new one pending.
        staging_d   = staging_q;
        if (LOAD) begin
            staging_d.digit = {HR_U, HR_L, MIN_U, MIN_L};
            staging_d.dp    = DP_MASK;
        end
        display_d = (boundary && pending_q) ? staging_q : display_q;
        pending_d = LOAD || (pending_q && !boundary);
    end

    always_comb begin
        blank = (BLANK_LEADING != 0) && (idx_q == 2'd3) && (display_q.digit[3] == 4'd0);
        lit   = (dwell_cnt_q >= GUARD_END) && (pwm_cnt_q < BRIGHT) && !blank;
        an_d  = lit ? ~(4'b0001 << idx_q) : AN_OFF;
        seg_d = lit ? ~pattern : SEG_OFF;
    end

    always_ff @(posedge CLK100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            dwell_cnt_q  <= '0;
            idx_q        <= 2'd3;
            pwm_cnt_q    <= '0;
            staging_q    <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            dwell_cnt_q  <= dwell_cnt_d;
            idx_q        <= idx_d;
            pwm_cnt_q    <= pwm_cnt_d;
            staging_q    <= staging_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= boundary;
        end
    end

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign FRAME_DONE = frame_done_q;

endmodule
